seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8: width of match_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load  input  1  pulse that latches pattern, pat_len and overlap_en.
REQ-006 SHALL have port pattern  input  WIDTH  pattern to detect; pattern[pat_len-1] is the first bit received.
REQ-007 SHALL have port pat_len  input  $clog2(WIDTH+1)  active pattern length.
REQ-008 SHALL have port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port in_valid  input  1  qualifies in_bit; a bit is consumed only when this is high.
REQ-010 SHALL have port in_bit  input  1  serial data bit, MSB-first stream.
REQ-011 SHALL have port match  output  1  registered one-cycle pulse per detection.
REQ-012 SHALL have port cfg_err  output  1  registered one-cycle pulse on a rejected load.
REQ-013 SHALL have port armed  output  1  high in state RUN.
REQ-014 SHALL have port match_count  output  CNT_W  saturating count of detections.

Function
REQ-015 SHALL implement FSM states IDLE (unconfigured, ignores in_valid) and RUN (detecting).
REQ-016 A load with 1 <= pat_len <= WIDTH SHALL latch the configuration, clear the history, fill counter and match_count, and enter RUN on the next edge.
REQ-017 A load with pat_len == 0 or pat_len > WIDTH SHALL pulse cfg_err for one cycle, enter IDLE and leave the previous configuration discarded.
REQ-018 In RUN, each in_valid cycle SHALL shift the history left ({hist[WIDTH-2:0], in_bit}) and increment the fill counter, which saturates at WIDTH.
REQ-019 A detection occurs when fill >= pat_len after the shift and hist[pat_len-1:0] == latched pattern[pat_len-1:0]; bits above pat_len are don't-care.
REQ-020 match SHALL assert in the cycle following the edge that consumed the completing bit, for exactly one cycle; latency is 1 clock.
REQ-021 With overlap_en latched 1, the history and fill SHALL be kept after a detection; with 0, fill SHALL be cleared to 0 on a detection, so the next match needs pat_len fresh bits.
REQ-022 Cycles with in_valid low SHALL neither shift nor change fill; they SHALL NOT break a partial match.
REQ-023 load and in_valid in the same cycle: load SHALL win and in_bit SHALL be discarded; match SHALL be 0 on the following cycle.
REQ-024 A load in RUN SHALL reconfigure immediately, per REQ-016 or REQ-017; an in-flight partial match is lost.
REQ-025 match_count SHALL increment on each detection and hold at 2^CNT_W-1 with no wrap.
REQ-026 The pattern, pat_len and overlap_en inputs SHALL be ignored except on cycles when load is high.

Reset
REQ-027 rst high SHALL immediately force IDLE and clear the history, fill and latched configuration, with match=0, cfg_err=0, armed=0 and match_count=0.
REQ-028 rst asserted mid-stream SHALL drop any partial match; after release, no match is allowed until a valid load and pat_len bits.

Configuration
REQ-029 Macro SEQ_DETECTOR_PARAM_COUNT_EN defined: match_count SHALL be implemented per REQ-025.
REQ-030 Macro SEQ_DETECTOR_PARAM_COUNT_EN undefined: the counter SHALL be omitted and match_count SHALL be driven constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-031 Set WIDTH=4, pattern=4'b1101, pat_len=4 and overlap=1, then feed 1101101101101101 with in_valid continuously high: match SHALL pulse after bits 4, 7, 10, 13 and 16, and match_count SHALL equal 5.
REQ-032 Use the same stream with overlap=0: match SHALL pulse after bits 4, 10 and 16, and match_count SHALL equal 3.
REQ-033 Use pattern 1101 with in_valid low for 3 cycles between each bit: the same match positions as REQ-031 SHALL occur, counted in consumed bits.
REQ-034 Load with pat_len=0 and then with pat_len=5 (WIDTH=4): each load SHALL pulse cfg_err, armed SHALL be 0, and a following stream SHALL produce no match.
REQ-035 Assert rst asynchronously after 110 of 1101: match and armed SHALL go to 0 immediately; after a reload, the bit 1 alone SHALL give no match.
REQ-036 Use CNT_W=2 with 5 overlapping detections: match_count SHALL saturate at 3; build without the macro: match_count SHALL stay 0 throughout.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time pattern length and overlap mode.
// Optional saturating match counter enabled by SEQ_DETECTOR_PARAM_COUNT_EN.
module seq_detector_param #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] pat_len,
    input  logic                       overlap_en,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       match,
    output logic                       cfg_err,
    output logic                       armed,
    output logic [CNT_W-1:0]           match_count
);
    localparam int LW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Handshake: a bit is consumed on a rising edge where in_valid is high,
    // the FSM is in RUN and load is low; load always takes priority.

    logic [0:0]       state_q,   state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LW-1:0]    len_q,     len_d;
    logic             ovl_q,     ovl_d;
    logic [WIDTH-1:0] hist_q,    hist_d;
    logic [LW-1:0]    fill_q,    fill_d;
    logic             match_q,   match_d;
    logic             cfg_err_q, cfg_err_d;

    logic [WIDTH-1:0] hist_shift;
    logic [WIDTH-1:0] len_mask;
    logic [LW-1:0]    fill_inc;
    logic             hit;
    logic             len_ok;

    always_comb begin
        hist_shift = {hist_q[WIDTH-2:0], in_bit};
        fill_inc   = (fill_q == LW'(WIDTH)) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            len_mask[i] = (int'(len_q) > i);
        end
        // Only the low pat_len bits of history take part in the compare.
        hit    = (fill_inc >= len_q) &&
                 (((hist_shift ^ pattern_q) & len_mask) == '0);
        len_ok = (pat_len != '0) && (pat_len <= LW'(WIDTH));
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;
        if (load) begin
            hist_d = '0;
            fill_d = '0;
            if (len_ok) begin
                state_d   = S_RUN;
                pattern_d = pattern;
                len_d     = pat_len;
                ovl_d     = overlap_en;
            end else begin
                state_d   = S_IDLE;
                pattern_d = '0;
                len_d     = '0;
                ovl_d     = 1'b0;
                cfg_err_d = 1'b1;
            end
        end else if (state_q == S_RUN && in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (hit) begin
                match_d = 1'b1;
                // Non-overlapping mode demands a fresh pat_len bits.
                if (!ovl_q) fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match   = match_q;
    assign cfg_err = cfg_err_q;
    assign armed   = (state_q == S_RUN);

`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load && len_ok) begin
            count_d = '0;
        end else if (match_d && count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule
